full_adder: RTL and testbench
=============================

Name: full_adder

Overview:
Ripple-style binary full adder. Default width is one bit, and parameterizable to a multi-bit word. It provides a combinational sum/carry path for immediate use, plus a registered, valid-qualified copy of the result for pipelined datapaths. It is the basic arithmetic leaf cell for the ADDER subsystem.

Parameters:
WIDTH, 1, operand width in bits (legal range 1..64).

Ports:
clk  input  1  rising-edge clock for the registered path.
rst  input  1  synchronous, active-high reset for the registered path.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
c_in  input  1  carry into bit 0.
sum  output  WIDTH  combinational sum, a + b + c_in modulo 2^WIDTH.
carry_out  output  1  combinational carry out of the MSB.
overflow  output  1  combinational two's-complement overflow: carry into MSB XOR carry_out.
in_valid  input  1  qualifies a/b/c_in for capture into the registered path.
sum_q  output  WIDTH  registered sum.
carry_out_q  output  1  registered carry_out.
overflow_q  output  1  registered overflow.
out_valid  output  1  high for the cycle after an accepted in_valid.

Behaviour:
- Combinational path:
  - sum, carry_out and overflow are pure functions of a, b and c_in, with no clock dependency.
  - They settle within the same delta/timestep as any input change.
  - They are unaffected by rst and by in_valid.
- Bit equations, bit i, c[0] = c_in:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]))
  - carry_out = c[WIDTH]
  - overflow = c[WIDTH-1] ^ c[WIDTH]
- WIDTH = 1 special case: overflow = c_in ^ carry_out.
- Arithmetic: the full result {carry_out, sum} equals a + b + c_in exactly, as a (WIDTH+1)-bit unsigned value. No saturation; sum wraps modulo 2^WIDTH.
- Registered path, latency 1:
  - On a rising clk edge with rst=0 and in_valid=1: sum_q, carry_out_q and overflow_q load the current combinational values, and out_valid is set to 1.
  - On a rising edge with rst=0 and in_valid=0: out_valid is set to 0, and sum_q/carry_out_q/overflow_q hold their previous values.
- Reset: on a rising edge with rst=1, sum_q=0, carry_out_q=0, overflow_q=0 and out_valid=0. rst has priority over in_valid.
- No backpressure: every valid input is accepted, so back-to-back in_valid yields back-to-back out_valid.
- Reset mid-stream: a result whose capture edge coincides with rst=1 is discarded, and out_valid is 0 the following cycle.
- Undriven/X inputs propagate X on the combinational outputs; no X-masking is performed.

Test Plan:
- WIDTH=1 truth table, inputs held 10 ns each, (a,b,c_in) -> (sum,carry_out):
  - 000 -> 0,0
  - 001 -> 1,0
  - 010 -> 1,0
  - 011 -> 0,1
  - 100 -> 1,0
  - 101 -> 0,1
  - 110 -> 0,1
  - 111 -> 1,1
- WIDTH=1 overflow: a=0, b=0, c_in=1 -> overflow=1; a=1, b=1, c_in=1 -> overflow=0.
- WIDTH=8 wrap and signed overflow:
  - a=0xFF, b=0x01, c_in=0 -> sum=0x00, carry_out=1, overflow=0.
  - a=0x7F, b=0x01, c_in=0 -> sum=0x80, carry_out=0, overflow=1.
- Registered path: rst=1 for 2 cycles -> sum_q=0, carry_out_q=0, out_valid=0. Then in_valid=1 with a=1, b=1, c_in=0 for one cycle -> next cycle sum_q=0, carry_out_q=1, out_valid=1; the cycle after, out_valid=0 and sum_q/carry_out_q hold.
- Back-to-back with reset: apply 3 consecutive valid inputs and assert rst on the edge that would capture the 2nd. Required: 1st result is captured, then all registered outputs are 0 with out_valid=0, then the 3rd result appears with out_valid=1.

Source files
------------

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Ripple-carry binary adder leaf cell for the ADDER subsystem. WIDTH defaults
// to a single bit and may be raised to 64. Two views of the same result:
//   * a combinational path (sum, carry_out, overflow) for immediate use;
//   * a registered, valid-qualified copy (sum_q, carry_out_q, overflow_q,
//     out_valid) with one cycle of latency for pipelined datapaths.
//
// Ports
//   clk          rising-edge clock for the registered path
//   rst          synchronous, active-high reset for the registered path
//   a, b         WIDTH-bit unsigned operands
//   c_in         carry into bit 0
//   sum          combinational a + b + c_in modulo 2^WIDTH
//   carry_out    combinational carry out of the MSB
//   overflow     combinational two's-complement overflow
//                (carry into MSB XOR carry out of MSB)
//   in_valid     qualifies a/b/c_in for capture into the registered path
//   sum_q        registered sum
//   carry_out_q  registered carry_out
//   overflow_q   registered overflow
//   out_valid    high for the cycle after an accepted in_valid
// -----------------------------------------------------------------------------
module full_adder #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_out_q,
  output logic             overflow_q,
  output logic             out_valid
);

  logic [WIDTH-1:0] sum_s;
  logic             carry_out_s;
  logic             overflow_s;

  logic [WIDTH-1:0] sum_r;
  logic             carry_out_r;
  logic             overflow_r;
  logic             out_valid_r;

  // Ripple carry chain: one full-adder stage per bit, carry vector kept local
  // so the chain does not form a combinational loop on a module-level signal.
  always_comb begin
    logic [WIDTH:0] c_v;
    c_v   = {(WIDTH+1){1'b0}};
    sum_s = {WIDTH{1'b0}};
    c_v[0] = c_in;
    for (int i = 0; i < WIDTH; i++) begin
      sum_s[i]  = a[i] ^ b[i] ^ c_v[i];
      c_v[i+1]  = (a[i] & b[i]) | (c_v[i] & (a[i] ^ b[i]));
    end
    carry_out_s = c_v[WIDTH];
    // For WIDTH = 1 the carry into the MSB is c_in itself, so this single
    // expression also covers the one-bit case.
    overflow_s  = c_v[WIDTH-1] ^ c_v[WIDTH];
  end

  // Combinational outputs are straight copies of the ripple result.
  always_comb begin
    sum       = sum_s;
    carry_out = carry_out_s;
    overflow  = overflow_s;
  end

  // Registered path: reset wins over in_valid; a result whose capture edge
  // coincides with rst is therefore discarded. Without in_valid the data
  // registers hold and only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r       <= {WIDTH{1'b0}};
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (in_valid) begin
      sum_r       <= sum_s;
      carry_out_r <= carry_out_s;
      overflow_r  <= overflow_s;
      out_valid_r <= 1'b1;
    end else begin
      sum_r       <= sum_r;
      carry_out_r <= carry_out_r;
      overflow_r  <= overflow_r;
      out_valid_r <= 1'b0;
    end
  end

  // Registered outputs driven directly from the flops.
  always_comb begin
    sum_q       = sum_r;
    carry_out_q = carry_out_r;
    overflow_q  = overflow_r;
    out_valid   = out_valid_r;
  end

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//
// Self-checking bench for full_adder. Three instances (WIDTH = 1, 8, 64) share
// clk, rst and in_valid. Expected values come from an arithmetic reference
// model: the unsigned sum a + b + c_in and the signed sum of the operands
// interpreted as two's-complement values, checked against the signed range.
// -----------------------------------------------------------------------------
module tb_full_adder;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic in_valid;

  // WIDTH = 1 instance
  logic [0:0]  a1, b1, sum1, sumq1;
  logic        c1, co1, ov1, coq1, ovq1, vld1;
  // WIDTH = 8 instance
  logic [7:0]  a8, b8, sum8, sumq8;
  logic        c8, co8, ov8, coq8, ovq8, vld8;
  // WIDTH = 64 instance
  logic [63:0] a64, b64, sum64, sumq64;
  logic        c64, co64, ov64, coq64, ovq64, vld64;

  int pass_cnt  = 0;
  int check_cnt = 0;

  full_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1), .c_in(c1),
    .sum(sum1), .carry_out(co1), .overflow(ov1), .in_valid(in_valid),
    .sum_q(sumq1), .carry_out_q(coq1), .overflow_q(ovq1), .out_valid(vld1)
  );

  full_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .a(a8), .b(b8), .c_in(c8),
    .sum(sum8), .carry_out(co8), .overflow(ov8), .in_valid(in_valid),
    .sum_q(sumq8), .carry_out_q(coq8), .overflow_q(ovq8), .out_valid(vld8)
  );

  full_adder #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst(rst), .a(a64), .b(b64), .c_in(c64),
    .sum(sum64), .carry_out(co64), .overflow(ov64), .in_valid(in_valid),
    .sum_q(sumq64), .carry_out_q(coq64), .overflow_q(ovq64), .out_valid(vld64)
  );

  // Reference: exact unsigned sum for sum/carry, signed range test for overflow.
  function automatic res_t ref_add(input int w, input logic [63:0] a,
                                   input logic [63:0] b, input logic cin);
    res_t r;
    logic [65:0] mask, ua, ub, full;
    logic signed [65:0] sa, sb, sc, ss, lo, hi;
    mask = (66'd1 << w) - 66'd1;
    ua   = {2'b00, a} & mask;
    ub   = {2'b00, b} & mask;
    full = ua + ub + {65'd0, cin};
    r.sum  = full[63:0] & mask[63:0];
    r.cout = full[w];
    sa = ua;
    if (ua[w-1]) sa = ua - (66'd1 << w);
    sb = ub;
    if (ub[w-1]) sb = ub - (66'd1 << w);
    sc = {65'd0, cin};
    ss = sa + sb + sc;
    hi = (66'sd1 <<< (w - 1)) - 66'sd1;
    lo = -(66'sd1 <<< (w - 1));
    r.ovf = (ss < lo) || (ss > hi);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    a1  = 1'($urandom);  b1  = 1'($urandom);  c1  = 1'($urandom);
    a8  = 8'($urandom);  b8  = 8'($urandom);  c8  = 1'($urandom);
    a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom}; c64 = 1'($urandom);
  endtask

  // rst held for two edges with in_valid high: registered outputs must be 0.
  task automatic test_reset();
    res_t e;
    rst = 1'b1; in_valid = 1'b1;
    randomize_inputs();
    tick(); tick();
    check_cnt++;
    if ({sumq1, coq1, ovq1, vld1} !== 4'b0000)
      $display("FAIL reset_w1: got %b expected 0000", {sumq1, coq1, ovq1, vld1});
    else pass_cnt++;
    check_cnt++;
    if ({sumq8, coq8, ovq8, vld8} !== 11'd0)
      $display("FAIL reset_w8: got %h expected 000", {sumq8, coq8, ovq8, vld8});
    else pass_cnt++;
    check_cnt++;
    if ({sumq64, coq64, ovq64, vld64} !== 67'd0)
      $display("FAIL reset_w64: got %h expected 0", {sumq64, coq64, ovq64, vld64});
    else pass_cnt++;
    // Combinational path must ignore rst.
    e = ref_add(8, {56'd0, a8}, {56'd0, b8}, c8);
    check_cnt++;
    if ({sum8, co8, ov8} !== {e.sum[7:0], e.cout, e.ovf})
      $display("FAIL comb_in_reset_w8: got %h expected %h",
               {sum8, co8, ov8}, {e.sum[7:0], e.cout, e.ovf});
    else pass_cnt++;
  endtask

  // One-bit truth table, each vector held 10 ns.
  task automatic test_truth_table();
    logic [7:0] exp_s;
    logic [7:0] exp_c;
    logic [2:0] v;
    exp_s = 8'b1001_0110;
    exp_c = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v  = 3'(i);
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      #10;
      check_cnt++;
      if ({sum1, co1} !== {exp_s[i], exp_c[i]})
        $display("FAIL truth_table_%0d: got %b%b expected %b%b",
                 i, sum1, co1, exp_s[i], exp_c[i]);
      else pass_cnt++;
    end
  endtask

  // Directed overflow and wrap boundaries for WIDTH 1 and 8.
  task automatic test_boundaries();
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b1; #1;
    check_cnt++;
    if (ov1 !== 1'b1) $display("FAIL ovf_w1_001: got %b expected 1", ov1);
    else pass_cnt++;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; #1;
    check_cnt++;
    if (ov1 !== 1'b0) $display("FAIL ovf_w1_111: got %b expected 0", ov1);
    else pass_cnt++;
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; #1;
    check_cnt++;
    if ({sum8, co8, ov8} !== {8'h00, 1'b1, 1'b0})
      $display("FAIL wrap_w8: got sum=%h co=%b ov=%b expected 00 1 0", sum8, co8, ov8);
    else pass_cnt++;
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0; #1;
    check_cnt++;
    if ({sum8, co8, ov8} !== {8'h80, 1'b0, 1'b1})
      $display("FAIL sovf_w8: got sum=%h co=%b ov=%b expected 80 0 1", sum8, co8, ov8);
    else pass_cnt++;
    a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'h0; c64 = 1'b1; #1;
    check_cnt++;
    if ({sum64, co64, ov64} !== {64'h0, 1'b1, 1'b0})
      $display("FAIL wrap_w64: got sum=%h co=%b ov=%b expected 0 1 0", sum64, co64, ov64);
    else pass_cnt++;
  endtask

  // Random operands on all widths against the arithmetic model.
  task automatic test_random_comb();
    res_t e1, e8, e64;
    for (int n = 0; n < 100; n++) begin
      randomize_inputs();
      #1;
      e1  = ref_add(1,  {63'd0, a1}, {63'd0, b1}, c1);
      e8  = ref_add(8,  {56'd0, a8}, {56'd0, b8}, c8);
      e64 = ref_add(64, a64, b64, c64);
      check_cnt++;
      if ({sum1, co1, ov1} !== {e1.sum[0], e1.cout, e1.ovf})
        $display("FAIL rand_comb_w1: got %b expected %b",
                 {sum1, co1, ov1}, {e1.sum[0], e1.cout, e1.ovf});
      else pass_cnt++;
      check_cnt++;
      if ({sum8, co8, ov8} !== {e8.sum[7:0], e8.cout, e8.ovf})
        $display("FAIL rand_comb_w8 a=%h b=%h c=%b: got %h expected %h", a8, b8, c8,
                 {sum8, co8, ov8}, {e8.sum[7:0], e8.cout, e8.ovf});
      else pass_cnt++;
      check_cnt++;
      if ({sum64, co64, ov64} !== {e64.sum, e64.cout, e64.ovf})
        $display("FAIL rand_comb_w64 a=%h b=%h c=%b: got %h expected %h", a64, b64, c64,
                 {sum64, co64, ov64}, {e64.sum, e64.cout, e64.ovf});
      else pass_cnt++;
    end
  endtask

  // Single capture on WIDTH = 1, then hold with in_valid low.
  task automatic test_registered();
    rst = 1'b1; in_valid = 1'b0;
    tick(); tick();
    check_cnt++;
    if ({sumq1, coq1, vld1} !== 3'b000)
      $display("FAIL reg_reset: got %b expected 000", {sumq1, coq1, vld1});
    else pass_cnt++;
    rst = 1'b0; in_valid = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    tick();
    check_cnt++;
    if ({sumq1, coq1, ovq1, vld1} !== 4'b0111)
      $display("FAIL reg_capture: got %b expected 0111", {sumq1, coq1, ovq1, vld1});
    else pass_cnt++;
    in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; c1 = 1'b1;
    tick();
    check_cnt++;
    if ({sumq1, coq1, ovq1, vld1} !== 4'b0110)
      $display("FAIL reg_hold: got %b expected 0110", {sumq1, coq1, ovq1, vld1});
    else pass_cnt++;
  endtask

  // Three valid inputs back to back on WIDTH = 8, rst on the 2nd capture edge.
  task automatic test_back_to_back_reset();
    res_t e;
    rst = 1'b0; in_valid = 1'b1;
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    e = ref_add(8, {56'd0, a8}, {56'd0, b8}, c8);
    tick();
    check_cnt++;
    if ({sumq8, coq8, ovq8, vld8} !== {e.sum[7:0], e.cout, e.ovf, 1'b1})
      $display("FAIL b2b_first: got %h expected %h",
               {sumq8, coq8, ovq8, vld8}, {e.sum[7:0], e.cout, e.ovf, 1'b1});
    else pass_cnt++;
    rst = 1'b1;
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    tick();
    check_cnt++;
    if ({sumq8, coq8, ovq8, vld8} !== 11'd0)
      $display("FAIL b2b_reset: got %h expected 000", {sumq8, coq8, ovq8, vld8});
    else pass_cnt++;
    rst = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
    e = ref_add(8, {56'd0, a8}, {56'd0, b8}, c8);
    tick();
    check_cnt++;
    if ({sumq8, coq8, ovq8, vld8} !== {e.sum[7:0], e.cout, e.ovf, 1'b1})
      $display("FAIL b2b_third: got %h expected %h",
               {sumq8, coq8, ovq8, vld8}, {e.sum[7:0], e.cout, e.ovf, 1'b1});
    else pass_cnt++;
    in_valid = 1'b0;
    tick();
  endtask

  // Random in_valid/rst traffic on WIDTH = 8 against a tracked expectation.
  task automatic test_random_registered();
    res_t e;
    logic [10:0] exp_q;
    exp_q = {sumq8, coq8, ovq8, vld8};
    // Start from a known state so exp_q is not taken from the DUT.
    rst = 1'b1; in_valid = 1'b0;
    tick();
    exp_q = 11'd0;
    for (int n = 0; n < 300; n++) begin
      rst      = ($urandom_range(15) == 0);
      in_valid = 1'($urandom);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      e = ref_add(8, {56'd0, a8}, {56'd0, b8}, c8);
      if (rst)           exp_q = 11'd0;
      else if (in_valid) exp_q = {e.sum[7:0], e.cout, e.ovf, 1'b1};
      else               exp_q = {exp_q[10:1], 1'b0};
      tick();
      check_cnt++;
      if ({sumq8, coq8, ovq8, vld8} !== exp_q)
        $display("FAIL rand_reg_%0d: got %h expected %h", n,
                 {sumq8, coq8, ovq8, vld8}, exp_q);
      else pass_cnt++;
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0;
    a64 = 64'h0; b64 = 64'h0; c64 = 1'b0;
    test_reset();
    test_truth_table();
    test_boundaries();
    test_random_comb();
    test_registered();
    test_back_to_back_reset();
    test_random_registered();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
